// File: rtl/candy_wb_sbuf_pkg.sv
// ---------------------------------------------------------------------------
// candy_wb_sbuf_pkg
//   Shared width and depth defaults for the candy writeback / store-buffer
//   stage. These sit beside the CPU's SRAM and register-file widths.
//   The package also provides a pointer-width helper that the FIFO uses.
//   It has no ports.
// ---------------------------------------------------------------------------
package candy_wb_sbuf_pkg;

    localparam int SBUF_DATA_W  = 24;  // SRAM data width
    localparam int SBUF_SRAM_AW = 17;  // SRAM address width
    localparam int SBUF_REG_AW  = 4;   // register address width
    localparam int SBUF_REG_W   = 24;  // register data width (<= data width)
    localparam int SBUF_DEPTH   = 4;   // store-buffer entries, power of two

    // Width of a read/write pointer into a buffer of the given depth.
    function automatic int sbuf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/candy_sbuf_fifo.sv
// ---------------------------------------------------------------------------
// candy_sbuf_fifo
//   This module is the in-order store buffer. It holds {addr, data} entries,
//   the read/write pointers that wrap modulo DEPTH, the occupancy count, and
//   a forwarding search that returns the youngest resident match.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   push                write {push_addr, push_data} at the tail (never when full)
//   push_addr/push_data entry being pushed
//   pop                 retire the head entry (never when empty)
//   count               occupied entries
//   head_addr/head_data head entry; 0 when empty
//   lk_addr             forwarding lookup address
//   lk_hit/lk_data      a resident entry matches; data of the youngest match
// ---------------------------------------------------------------------------
module candy_sbuf_fifo
    import candy_wb_sbuf_pkg::*;
#(
    parameter int DATA_W = SBUF_DATA_W,
    parameter int AW     = SBUF_SRAM_AW,
    parameter int DEPTH  = SBUF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [AW-1:0]     push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [AW-1:0]     head_addr,
    output logic [DATA_W-1:0] head_data,
    input  logic [AW-1:0]     lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data
);

    localparam int PTR_W = sbuf_ptr_w(DEPTH);

    logic [AW-1:0]     addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // NOTE: the storage array has no reset. Validity comes only from count
    // and the pointers, so clearing the array would add reset fan-out for no
    // benefit.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments. All reads in this
    // block see pre-edge values, so push and pop in the same cycle compose
    // correctly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;  // idle, or push and pop together: unchanged
            endcase
        end
    end

    assign head_addr = (count != '0) ? addr_mem[rd_ptr] : '0;
    assign head_data = (count != '0) ? data_mem[rd_ptr] : '0;

    // The search walks from the head (oldest) to the tail (youngest), so a
    // later match overrides an earlier one. Only entries resident before
    // this edge are visible: the head being popped is still searched, and
    // the store being pushed is not yet searched.
    logic [PTR_W-1:0] idx;

    // NOTE: every output of this always_comb gets a default before the loop.
    // Without those defaults a latch would be inferred for the no-match case.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/candy_wb_sbuf.sv
// ---------------------------------------------------------------------------
// candy_wb_sbuf
//   This is the writeback stage of the candy CPU. Register-file writes are
//   registered and never stall. SRAM stores are queued in a DEPTH-entry
//   buffer and drained to the SRAM port through a valid/ready handshake. The
//   stage also provides store-to-load forwarding and a stall to upstream.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wb_enable                instruction valid; other inputs are ignored when 0
//   is_mem                   1 = SRAM store, 0 = register write
//   result                   write data
//   sram_result_addr         store address
//   reg_addr                 destination register
//   wb_stall                 store presented while buffer full (hold upstream)
//   sram_write_enable        head entry valid
//   sram_ready               SRAM accepts the presented write
//   sram_wdata/sram_waddr    head entry; 0 when empty
//   reg_write_enable         registered register-file write strobe
//   reg_waddr/reg_wdata      registered register address/data (hold when idle)
//   ld_addr                  forwarding lookup address
//   ld_hit/ld_data           youngest buffered match; data 0 on miss
//   sb_count/sb_empty        buffer occupancy
// ---------------------------------------------------------------------------
module candy_wb_sbuf
    import candy_wb_sbuf_pkg::*;
#(
    parameter int DATA_W  = SBUF_DATA_W,
    parameter int SRAM_AW = SBUF_SRAM_AW,
    parameter int REG_AW  = SBUF_REG_AW,
    parameter int REG_W   = SBUF_REG_W,
    parameter int DEPTH   = SBUF_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_enable,
    input  logic               is_mem,
    input  logic [DATA_W-1:0]  result,
    input  logic [SRAM_AW-1:0] sram_result_addr,
    input  logic [REG_AW-1:0]  reg_addr,
    output logic               wb_stall,
    output logic               sram_write_enable,
    input  logic               sram_ready,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic [SRAM_AW-1:0] sram_waddr,
    output logic               reg_write_enable,
    output logic [REG_AW-1:0]  reg_waddr,
    output logic [REG_W-1:0]   reg_wdata,
    input  logic [SRAM_AW-1:0] ld_addr,
    output logic               ld_hit,
    output logic [DATA_W-1:0]  ld_data,
    output logic [CNT_W-1:0]   sb_count,
    output logic               sb_empty
);

    logic sb_full;
    logic push;
    logic pop;

    // Full is judged on registered occupancy only. As a result a store is
    // refused even when the head pops in the same cycle, and wb_stall has no
    // combinational path from sram_ready.
    assign sb_full           = (sb_count == CNT_W'(DEPTH));
    assign sb_empty          = (sb_count == '0);
    assign push              = wb_enable && is_mem && !sb_full;
    assign wb_stall          = wb_enable && is_mem && sb_full;
    assign sram_write_enable = !sb_empty;
    assign pop               = sram_write_enable && sram_ready;

    candy_sbuf_fifo #(
        .DATA_W (DATA_W),
        .AW     (SRAM_AW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (sram_result_addr),
        .push_data (result),
        .pop       (pop),
        .count     (sb_count),
        .head_addr (sram_waddr),
        .head_data (sram_wdata),
        .lk_addr   (ld_addr),
        .lk_hit    (ld_hit),
        .lk_data   (ld_data)
    );

    // Register path: one write per cycle, one-cycle latency. Address and
    // data hold their last value while no write is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_enable <= 1'b0;
            reg_waddr        <= '0;
            reg_wdata        <= '0;
        end else if (wb_enable && !is_mem) begin
            reg_write_enable <= 1'b1;
            reg_waddr        <= reg_addr;
            reg_wdata        <= result[REG_W-1:0];
        end else begin
            reg_write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_candy_wb_sbuf.sv
// ---------------------------------------------------------------------------
// tb_candy_wb_sbuf
//   Self-checking bench for candy_wb_sbuf. Directed scenarios are followed
//   by a randomized run against a queue-based model of the store buffer.
// ---------------------------------------------------------------------------
module tb_candy_wb_sbuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable;
    logic        is_mem;
    logic [23:0] result;
    logic [16:0] sram_result_addr;
    logic [3:0]  reg_addr;
    logic        wb_stall;
    logic        sram_write_enable;
    logic        sram_ready;
    logic [23:0] sram_wdata;
    logic [16:0] sram_waddr;
    logic        reg_write_enable;
    logic [3:0]  reg_waddr;
    logic [23:0] reg_wdata;
    logic [16:0] ld_addr;
    logic        ld_hit;
    logic [23:0] ld_data;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int n_checks = 0;
    int n_pass   = 0;

    candy_wb_sbuf dut (
        .clk               (clk),
        .rst               (rst),
        .wb_enable         (wb_enable),
        .is_mem            (is_mem),
        .result            (result),
        .sram_result_addr  (sram_result_addr),
        .reg_addr          (reg_addr),
        .wb_stall          (wb_stall),
        .sram_write_enable (sram_write_enable),
        .sram_ready        (sram_ready),
        .sram_wdata        (sram_wdata),
        .sram_waddr        (sram_waddr),
        .reg_write_enable  (reg_write_enable),
        .reg_waddr         (reg_waddr),
        .reg_wdata         (reg_wdata),
        .ld_addr           (ld_addr),
        .ld_hit            (ld_hit),
        .ld_data           (ld_data),
        .sb_count          (sb_count),
        .sb_empty          (sb_empty)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge. Checks happen a further
    // 1 unit later, well away from the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic mem, input logic [23:0] res,
                         input logic [16:0] addr, input logic [3:0] ra, input logic rdy);
        wb_enable        = en;
        is_mem           = mem;
        result           = res;
        sram_result_addr = addr;
        reg_addr         = ra;
        sram_ready       = rdy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        ld_addr = 17'h0;
        #1;
        n_checks++; if (reg_write_enable !== 1'b0) $display("FAIL reset_rwe got %b want 0", reg_write_enable); else n_pass++;
        n_checks++; if (reg_waddr !== 4'h0) $display("FAIL reset_waddr got %h want 0", reg_waddr); else n_pass++;
        n_checks++; if (reg_wdata !== 24'h0) $display("FAIL reset_wdata got %h want 0", reg_wdata); else n_pass++;
        n_checks++; if (sb_count !== 3'd0) $display("FAIL reset_count got %0d want 0", sb_count); else n_pass++;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", sb_empty); else n_pass++;
        n_checks++; if (sram_write_enable !== 1'b0) $display("FAIL reset_swe got %b want 0", sram_write_enable); else n_pass++;
        n_checks++; if (sram_wdata !== 24'h0 || sram_waddr !== 17'h0) $display("FAIL reset_head got %h/%h want 0/0", sram_waddr, sram_wdata); else n_pass++;
        n_checks++; if (ld_hit !== 1'b0 || ld_data !== 24'h0) $display("FAIL reset_ld got %b/%h want 0/0", ld_hit, ld_data); else n_pass++;
        n_checks++; if (wb_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", wb_stall); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL post_reset_empty got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_reg_write;
        drive(1, 0, 24'h37c549, 17'h0, 4'h4, 0);
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        #1;
        n_checks++; if (reg_write_enable !== 1'b1) $display("FAIL regw_rwe got %b want 1", reg_write_enable); else n_pass++;
        n_checks++; if (reg_waddr !== 4'h4) $display("FAIL regw_waddr got %h want 4", reg_waddr); else n_pass++;
        n_checks++; if (reg_wdata !== 24'h37c549) $display("FAIL regw_wdata got %h want 37c549", reg_wdata); else n_pass++;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL regw_no_store got empty=%b want 1", sb_empty); else n_pass++;
        tick();
        n_checks++; if (reg_write_enable !== 1'b0) $display("FAIL regw_rwe_drop got %b want 0", reg_write_enable); else n_pass++;
        n_checks++; if (reg_waddr !== 4'h4 || reg_wdata !== 24'h37c549) $display("FAIL regw_hold got %h/%h want 4/37c549", reg_waddr, reg_wdata); else n_pass++;
    endtask

    task automatic test_store;
        drive(1, 1, 24'h37c549, 17'd11, 4'h0, 1);
        #1;
        n_checks++; if (sram_write_enable !== 1'b0 || wb_stall !== 1'b0) $display("FAIL store_pre got swe=%b stall=%b want 0/0", sram_write_enable, wb_stall); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 1);
        #1;
        n_checks++; if (sram_write_enable !== 1'b1) $display("FAIL store_swe got %b want 1", sram_write_enable); else n_pass++;
        n_checks++; if (sram_waddr !== 17'd11 || sram_wdata !== 24'h37c549) $display("FAIL store_head got %0d/%h want 11/37c549", sram_waddr, sram_wdata); else n_pass++;
        n_checks++; if (sb_count !== 3'd1) $display("FAIL store_count got %0d want 1", sb_count); else n_pass++;
        tick();
        n_checks++; if (sram_write_enable !== 1'b0 || sb_empty !== 1'b1) $display("FAIL store_drained got swe=%b empty=%b want 0/1", sram_write_enable, sb_empty); else n_pass++;
        n_checks++; if (sram_waddr !== 17'h0 || sram_wdata !== 24'h0) $display("FAIL store_empty_head got %h/%h want 0/0", sram_waddr, sram_wdata); else n_pass++;
    endtask

    task automatic test_backpressure;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 24'ha00000 | 24'(i), 17'(i), 4'h0, 0);
            #1;
            n_checks++; if (wb_stall !== 1'b0) $display("FAIL bp_stall_%0d got %b want 0", i, wb_stall); else n_pass++;
            tick();
        end
        drive(1, 1, 24'ha00005, 17'd5, 4'h0, 0);
        #1;
        n_checks++; if (wb_stall !== 1'b1) $display("FAIL bp_stall_full got %b want 1", wb_stall); else n_pass++;
        n_checks++; if (sb_count !== 3'd4) $display("FAIL bp_count_full got %0d want 4", sb_count); else n_pass++;
        n_checks++; if (sram_waddr !== 17'd1) $display("FAIL bp_head got %0d want 1", sram_waddr); else n_pass++;
        tick();
        n_checks++; if (sb_count !== 3'd4 || sram_waddr !== 17'd1) $display("FAIL bp_hold got count=%0d head=%0d want 4/1", sb_count, sram_waddr); else n_pass++;
        sram_ready = 1'b1;
        #1;
        n_checks++; if (wb_stall !== 1'b1) $display("FAIL bp_stall_with_pop got %b want 1", wb_stall); else n_pass++;
        tick();
        n_checks++; if (wb_stall !== 1'b0 || sb_count !== 3'd3) $display("FAIL bp_after_pop got stall=%b count=%0d want 0/3", wb_stall, sb_count); else n_pass++;
        n_checks++; if (sram_waddr !== 17'd2) $display("FAIL bp_order2 got %0d want 2", sram_waddr); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 1);
        #1;
        n_checks++; if (sb_count !== 3'd3 || sram_waddr !== 17'd3) $display("FAIL bp_order3 got count=%0d head=%0d want 3/3", sb_count, sram_waddr); else n_pass++;
        tick();
        n_checks++; if (sram_waddr !== 17'd4 || sram_wdata !== 24'ha00004) $display("FAIL bp_order4 got %0d/%h want 4/a00004", sram_waddr, sram_wdata); else n_pass++;
        tick();
        n_checks++; if (sram_waddr !== 17'd5 || sram_wdata !== 24'ha00005 || sb_count !== 3'd1) $display("FAIL bp_order5 got %0d/%h/%0d want 5/a00005/1", sram_waddr, sram_wdata, sb_count); else n_pass++;
        tick();
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL bp_drained got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_forwarding;
        ld_addr = 17'd7;
        drive(1, 1, 24'h000001, 17'd7, 4'h0, 0);
        #1;
        n_checks++; if (ld_hit !== 1'b0) $display("FAIL fwd_push_excluded got %b want 0", ld_hit); else n_pass++;
        tick();
        drive(1, 1, 24'h000002, 17'd7, 4'h0, 0);
        #1;
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 24'h000001) $display("FAIL fwd_one got %b/%h want 1/000001", ld_hit, ld_data); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        #1;
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 24'h000002) $display("FAIL fwd_youngest got %b/%h want 1/000002", ld_hit, ld_data); else n_pass++;
        ld_addr = 17'd8;
        #1;
        n_checks++; if (ld_hit !== 1'b0 || ld_data !== 24'h0) $display("FAIL fwd_miss got %b/%h want 0/0", ld_hit, ld_data); else n_pass++;
        drive(1, 1, 24'h000005, 17'd8, 4'h0, 0);
        #1;
        n_checks++; if (ld_hit !== 1'b0) $display("FAIL fwd_push8_excluded got %b want 0", ld_hit); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 1);
        #1;
        n_checks++; if (ld_hit !== 1'b1 || ld_data !== 24'h000005 || sb_count !== 3'd3) $display("FAIL fwd_hit8 got %b/%h/%0d want 1/000005/3", ld_hit, ld_data, sb_count); else n_pass++;
        tick();
        tick();
        n_checks++; if (sb_count !== 3'd1 || ld_hit !== 1'b1 || ld_data !== 24'h000005) $display("FAIL fwd_popping_head got %0d/%b/%h want 1/1/000005", sb_count, ld_hit, ld_data); else n_pass++;
        ld_addr = 17'd7;
        #1;
        n_checks++; if (ld_hit !== 1'b0) $display("FAIL fwd_retired7 got %b want 0", ld_hit); else n_pass++;
        tick();
        ld_addr = 17'd8;
        #1;
        n_checks++; if (ld_hit !== 1'b0 || sb_empty !== 1'b1) $display("FAIL fwd_empty got hit=%b empty=%b want 0/1", ld_hit, sb_empty); else n_pass++;
    endtask

    task automatic test_simultaneous;
        drive(1, 1, 24'h000020, 17'd20, 4'h0, 0);
        tick();
        drive(1, 1, 24'h000021, 17'd21, 4'h0, 0);
        tick();
        drive(1, 1, 24'h000022, 17'd22, 4'h0, 1);
        #1;
        n_checks++; if (sb_count !== 3'd2) $display("FAIL sim_pre_count got %0d want 2", sb_count); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        #1;
        n_checks++; if (sb_count !== 3'd2 || sram_waddr !== 17'd21) $display("FAIL sim_push_pop got count=%0d head=%0d want 2/21", sb_count, sram_waddr); else n_pass++;
        drive(1, 1, 24'h000023, 17'd23, 4'h0, 0);
        tick();
        drive(1, 1, 24'h000024, 17'd24, 4'h0, 0);
        tick();
        drive(1, 1, 24'h000025, 17'd25, 4'h0, 0);
        #1;
        n_checks++; if (wb_stall !== 1'b1) $display("FAIL sim_stall got %b want 1", wb_stall); else n_pass++;
        tick();
        drive(1, 0, 24'h5a5a5a, 17'h0, 4'h9, 0);
        #1;
        n_checks++; if (wb_stall !== 1'b0) $display("FAIL sim_regw_nostall got %b want 0", wb_stall); else n_pass++;
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 1);
        #1;
        n_checks++; if (reg_write_enable !== 1'b1 || reg_waddr !== 4'h9 || reg_wdata !== 24'h5a5a5a) $display("FAIL sim_regw got %b/%h/%h want 1/9/5a5a5a", reg_write_enable, reg_waddr, reg_wdata); else n_pass++;
        n_checks++; if (sb_count !== 3'd4) $display("FAIL sim_full_count got %0d want 4", sb_count); else n_pass++;
        repeat (4) tick();
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL sim_drained got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_random;
        logic [16:0] q_addr[$];
        logic [23:0] q_data[$];
        logic        exp_rwe;
        logic [3:0]  exp_ra;
        logic [23:0] exp_rd;
        logic        en, mem, rdy, exp_hit;
        logic [23:0] res, exp_ld;
        logic [16:0] addr;
        logic [3:0]  ra;
        int          sz;

        // Establish a known register-path state before the random run.
        drive(1, 0, 24'h123456, 17'h0, 4'h3, 0);
        tick();
        exp_rwe = 1'b1;
        exp_ra  = 4'h3;
        exp_rd  = 24'h123456;

        for (int cyc = 0; cyc < 600; cyc++) begin
            en   = ($urandom_range(0, 3) != 0);
            mem  = ($urandom_range(0, 2) != 0);
            res  = 24'($urandom);
            addr = 17'($urandom_range(0, 7));
            ra   = 4'($urandom_range(0, 15));
            rdy  = ($urandom_range(0, 2) == 0);
            drive(en, mem, res, addr, ra, rdy);
            ld_addr = 17'($urandom_range(0, 7));
            #1;

            sz      = q_addr.size();
            exp_hit = 1'b0;
            exp_ld  = 24'h0;
            for (int k = sz - 1; k >= 0; k--) begin
                if (q_addr[k] == ld_addr) begin
                    exp_hit = 1'b1;
                    exp_ld  = q_data[k];
                    break;
                end
            end

            n_checks++; if (wb_stall !== (en && mem && sz == DEPTH)) $display("FAIL rnd_stall cyc %0d got %b size %0d", cyc, wb_stall, sz); else n_pass++;
            n_checks++; if (sb_count !== 3'(sz) || sb_empty !== (sz == 0)) $display("FAIL rnd_count cyc %0d got %0d/%b want %0d", cyc, sb_count, sb_empty, sz); else n_pass++;
            n_checks++; if (sram_write_enable !== (sz != 0)) $display("FAIL rnd_swe cyc %0d got %b want %b", cyc, sram_write_enable, sz != 0); else n_pass++;
            n_checks++; if (sram_waddr !== ((sz != 0) ? q_addr[0] : 17'h0) || sram_wdata !== ((sz != 0) ? q_data[0] : 24'h0)) $display("FAIL rnd_head cyc %0d got %h/%h", cyc, sram_waddr, sram_wdata); else n_pass++;
            n_checks++; if (ld_hit !== exp_hit || ld_data !== exp_ld) $display("FAIL rnd_fwd cyc %0d got %b/%h want %b/%h", cyc, ld_hit, ld_data, exp_hit, exp_ld); else n_pass++;
            n_checks++; if (reg_write_enable !== exp_rwe || reg_waddr !== exp_ra || reg_wdata !== exp_rd) $display("FAIL rnd_reg cyc %0d got %b/%h/%h want %b/%h/%h", cyc, reg_write_enable, reg_waddr, reg_wdata, exp_rwe, exp_ra, exp_rd); else n_pass++;

            // Model update for this edge, based on pre-edge occupancy.
            if (sz != 0 && rdy) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (en && mem && sz < DEPTH) begin
                q_addr.push_back(addr);
                q_data.push_back(res);
            end
            if (en && !mem) begin
                exp_rwe = 1'b1;
                exp_ra  = ra;
                exp_rd  = res;
            end else begin
                exp_rwe = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain;
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        repeat (DEPTH) tick();  // let anything left from the random run drain
        sram_ready = 1'b1;
        repeat (DEPTH) tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 24'hb00000 | 24'(i), 17'(i), 4'h0, 0);
            tick();
        end
        drive(0, 0, 24'h0, 17'h0, 4'h0, 1);
        ld_addr = 17'd2;
        #1;
        n_checks++; if (sb_count !== 3'd3 || sram_write_enable !== 1'b1) $display("FAIL rstmid_pre got %0d/%b want 3/1", sb_count, sram_write_enable); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (sb_count !== 3'd0 || sram_write_enable !== 1'b0 || sb_empty !== 1'b1) $display("FAIL rstmid_clear got %0d/%b/%b want 0/0/1", sb_count, sram_write_enable, sb_empty); else n_pass++;
        n_checks++; if (ld_hit !== 1'b0) $display("FAIL rstmid_ld got %b want 0", ld_hit); else n_pass++;
        rst = 1'b0;
        tick();
        drive(1, 1, 24'h0c0ffe, 17'd30, 4'h0, 0);
        tick();
        drive(0, 0, 24'h0, 17'h0, 4'h0, 0);
        #1;
        n_checks++; if (sb_count !== 3'd1 || sram_waddr !== 17'd30 || sram_wdata !== 24'h0c0ffe) $display("FAIL rstmid_restart got %0d/%0d/%h want 1/30/0c0ffe", sb_count, sram_waddr, sram_wdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_store();
        test_backpressure();
        test_forwarding();
        test_simultaneous();
        test_random();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
